// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: tick generator, TX/RX FIFOs, TX/RX FSMs, host push/pop interface.
// Define UART_PARITY_EN to build parity generation/checking; without it parity_mode is ignored.
module uart_core_param #(
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE     = 16,
  parameter int DVSR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] baud_dvsr,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  input  logic [DATA_SIZE-1:0]  tx_wdata,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic                  tx_busy,
  output logic [DATA_SIZE-1:0]  rx_rdata,
  input  logic                  rx_rd,
  output logic                  rx_empty,
  input  logic                  err_clr,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  rx,
  output logic                  tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * SAMPLE);
  localparam int NW = $clog2(DATA_SIZE);
  localparam logic [CW-1:0] BIT_LAST   = CW'(SAMPLE - 1);
  localparam logic [CW-1:0] STOP2_LAST = CW'(2 * SAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(SAMPLE / 2 - 1);
  localparam logic [NW-1:0] DATA_LAST  = NW'(DATA_SIZE - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_en_in, par_odd_in;
  assign par_en_in  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign par_odd_in = (parity_mode == 2'b10);
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  logic parity_mode_unused;
  assign parity_mode_unused = ^parity_mode;
`endif

  logic [DVSR_WIDTH-1:0] tick_cnt;
  logic                  s_tick;
  assign s_tick = (tick_cnt == '0);

  always_ff @(posedge clk or posedge reset)
    if (reset)       tick_cnt <= '0;
    else if (s_tick) tick_cnt <= baud_dvsr;
    else             tick_cnt <= tick_cnt - DVSR_WIDTH'(1);

  // TX FIFO; a push while full is accepted only when the same cycle pops
  logic [DATA_SIZE-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wptr, tx_rptr, tx_wptr_nx, tx_rptr_nx;
  logic                 tx_empty, tx_pop, tx_push;
  assign tx_push    = tx_wr && (!tx_full || tx_pop);
  assign tx_wptr_nx = tx_wptr + (AW+1)'(tx_push);
  assign tx_rptr_nx = tx_rptr + (AW+1)'(tx_pop);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_empty <= 1'b1;
      tx_full  <= 1'b0;
    end else begin
      tx_wptr  <= tx_wptr_nx;
      tx_rptr  <= tx_rptr_nx;
      tx_empty <= (tx_wptr_nx == tx_rptr_nx);
      tx_full  <= (tx_wptr_nx[AW] != tx_rptr_nx[AW]) && (tx_wptr_nx[AW-1:0] == tx_rptr_nx[AW-1:0]);
    end

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= tx_wdata;

  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [NW-1:0]        tx_n;
  logic [DATA_SIZE-1:0] tx_sh, tx_head;
  logic                 tx_stop2, tx_reg, tx_stop_done;
`ifdef UART_PARITY_EN
  logic                 tx_par_en, tx_par_bit;
`endif
  assign tx_head      = tx_mem[tx_rptr[AW-1:0]];
  assign tx_stop_done = (tx_state == STOP) && (tx_cnt == (tx_stop2 ? STOP2_LAST : BIT_LAST));
  // Popping straight out of the last stop tick gives back-to-back frames with no idle gap
  assign tx_pop       = s_tick && !tx_empty && ((tx_state == IDLE) || tx_stop_done);
  assign tx_busy      = (tx_state != IDLE) || !tx_empty;
  assign tx           = tx_reg;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state   <= IDLE;
      tx_cnt     <= '0;
      tx_n       <= '0;
      tx_sh      <= '0;
      tx_stop2   <= 1'b0;
      tx_reg     <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_state   <= START;
      tx_cnt     <= '0;
      tx_sh      <= tx_head;
      tx_stop2   <= stop2;
      tx_reg     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_en  <= par_en_in;
      tx_par_bit <= (^tx_head) ^ par_odd_in;
`endif
    end else if (s_tick) begin
      case (tx_state)
        IDLE: tx_reg <= 1'b1;
        START:
          if (tx_cnt == BIT_LAST) begin
            tx_state <= DATA;
            tx_cnt   <= '0;
            tx_n     <= '0;
            tx_reg   <= tx_sh[0];
          end else tx_cnt <= tx_cnt + CW'(1);
        DATA:
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_sh  <= tx_sh >> 1;
            if (tx_n == DATA_LAST) begin
`ifdef UART_PARITY_EN
              if (tx_par_en) begin
                tx_state <= PARITY;
                tx_reg   <= tx_par_bit;
              end else
`endif
              begin
                tx_state <= STOP;
                tx_reg   <= 1'b1;
              end
            end else begin
              tx_n   <= tx_n + NW'(1);
              tx_reg <= tx_sh[1];
            end
          end else tx_cnt <= tx_cnt + CW'(1);
`ifdef UART_PARITY_EN
        PARITY:
          if (tx_cnt == BIT_LAST) begin
            tx_state <= STOP;
            tx_cnt   <= '0;
            tx_reg   <= 1'b1;
          end else tx_cnt <= tx_cnt + CW'(1);
`endif
        STOP:
          if (tx_stop_done) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
          end else tx_cnt <= tx_cnt + CW'(1);
        default: begin
          tx_state <= IDLE;
          tx_reg   <= 1'b1;
        end
      endcase
    end

  logic rx_s1, rx_s2;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end

  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [NW-1:0]        rx_n;
  logic [DATA_SIZE-1:0] rx_sh;
  logic                 rx_push;
`ifdef UART_PARITY_EN
  logic                 rx_par_en, rx_par_odd, rx_par_bit;
`else
  assign parity_err = 1'b0;
`endif

  // Error flags: a set in the same cycle as err_clr wins because it is assigned last
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_n       <= '0;
      rx_sh      <= '0;
      rx_push    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_push <= 1'b0;
      if (err_clr) begin
        frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (rx_state)
        IDLE:
          if (!rx_s2) begin
            rx_state   <= START;
            rx_cnt     <= '0;
`ifdef UART_PARITY_EN
            rx_par_en  <= par_en_in;
            rx_par_odd <= par_odd_in;
`endif
          end
        START:
          if (s_tick) begin
            if (rx_cnt == HALF_LAST) begin
              rx_state <= rx_s2 ? IDLE : DATA;
              rx_cnt   <= '0;
              rx_n     <= '0;
            end else rx_cnt <= rx_cnt + CW'(1);
          end
        DATA:
          if (s_tick) begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt <= '0;
              rx_sh  <= {rx_s2, rx_sh[DATA_SIZE-1:1]};
              if (rx_n == DATA_LAST) begin
`ifdef UART_PARITY_EN
                rx_state <= rx_par_en ? PARITY : STOP;
`else
                rx_state <= STOP;
`endif
              end else rx_n <= rx_n + NW'(1);
            end else rx_cnt <= rx_cnt + CW'(1);
          end
`ifdef UART_PARITY_EN
        PARITY:
          if (s_tick) begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt     <= '0;
              rx_par_bit <= rx_s2;
              rx_state   <= STOP;
            end else rx_cnt <= rx_cnt + CW'(1);
          end
`endif
        STOP:
          if (s_tick) begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt   <= '0;
              rx_push  <= 1'b1;
              rx_state <= IDLE;
              if (!rx_s2) frame_err <= 1'b1;
`ifdef UART_PARITY_EN
              if (rx_par_en && (rx_par_bit != ((^rx_sh) ^ rx_par_odd))) parity_err <= 1'b1;
`endif
            end else rx_cnt <= rx_cnt + CW'(1);
          end
        default: rx_state <= IDLE;
      endcase
    end

  logic [DATA_SIZE-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wptr, rx_rptr, rx_wptr_nx, rx_rptr_nx;
  logic                 rx_full, rx_do_rd, rx_do_wr;
  assign rx_do_rd   = rx_rd && !rx_empty;
  assign rx_do_wr   = rx_push && (!rx_full || rx_do_rd);
  assign rx_wptr_nx = rx_wptr + (AW+1)'(rx_do_wr);
  assign rx_rptr_nx = rx_rptr + (AW+1)'(rx_do_rd);
  assign rx_rdata   = rx_empty ? '0 : rx_mem[rx_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_empty <= 1'b1;
      rx_full  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rx_wptr  <= rx_wptr_nx;
      rx_rptr  <= rx_rptr_nx;
      rx_empty <= (rx_wptr_nx == rx_rptr_nx);
      rx_full  <= (rx_wptr_nx[AW] != rx_rptr_nx[AW]) && (rx_wptr_nx[AW-1:0] == rx_rptr_nx[AW-1:0]);
      if (rx_push && rx_full && !rx_do_rd) overrun <= 1'b1;
      else if (err_clr)                     overrun <= 1'b0;
    end

  always_ff @(posedge clk)
    if (rx_do_wr) rx_mem[rx_wptr[AW-1:0]] <= rx_sh;

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: TX waveform, loopback, RX error flags, overrun, mid-frame reset.
module tb_uart_core_param;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_dvsr = 16'd3;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop2 = 1'b0;
  logic [7:0]  tx_wdata = '0;
  logic        tx_wr = 1'b0;
  logic        tx_full, tx_busy, rx_empty, parity_err, frame_err, overrun, tx_pin;
  logic [7:0]  rx_rdata;
  logic        rx_rd = 1'b0;
  logic        err_clr = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_pin;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  assign rx_pin = loop_en ? tx_pin : rx_drv;

  always #5 clk = ~clk;

  uart_core_param #(.DATA_SIZE(8), .FIFO_DEPTH(4), .SAMPLE(16), .DVSR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .baud_dvsr(baud_dvsr), .parity_mode(parity_mode), .stop2(stop2),
    .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full), .tx_busy(tx_busy),
    .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty), .err_clr(err_clr),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .rx(rx_pin), .tx(tx_pin)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Push a word into the TX FIFO; when looped back, it is also expected on the RX side
  task automatic applyStimulus(input logic [7:0] w, input bit expect_rx);
    if (expect_rx) exp_q.push_back({24'h0, w});
    tx_wdata = w;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] w, input bit use_par, input bit par_bit,
                           input bit stop_low, input bit store);
    if (store) exp_q.push_back({24'h0, w});
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = w[i];
      repeat (64) @(negedge clk);
    end
    if (use_par) begin
      rx_drv = par_bit;
      repeat (64) @(negedge clk);
    end
    if (stop_low) begin
      rx_drv = 1'b0;
      repeat (44) @(negedge clk);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
    end else begin
      rx_drv = 1'b1;
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic popAndCheck(input string tag);
    int n = 0;
    logic [31:0] exp;
    while (rx_empty && n < 2500) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_avail"}, {31'h0, rx_empty}, 32'h0);
    if (rx_empty) return;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h100;
    checkOutput(tag, {24'h0, rx_rdata}, exp);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  // Reads the RX FIFO in exactly the cycle a received word is being pushed
  task automatic readOnPush(input string tag);
    int n = 0;
    logic [31:0] exp;
    while (!dut.rx_push && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_push_seen"}, {31'h0, dut.rx_push}, 32'h1);
    if (!dut.rx_push) return;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h100;
    checkOutput({tag, "_head"}, {24'h0, rx_rdata}, exp);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  function automatic logic [15:0] frameBits(input logic [7:0] w, input bit pe, input bit odd);
    logic [15:0] f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = w[i];
    if (pe) f[9] = (^w) ^ odd;
    return f;
  endfunction

  task automatic captureFrame(input string tag, input logic [15:0] exp_bits, input int nbits);
    int n = 0;
    while (tx_pin && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_start"}, {31'h0, tx_pin}, 32'h0);
    if (tx_pin) return;
    repeat (32) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i != 0) repeat (64) @(negedge clk);
      checkOutput($sformatf("%s_bit%0d", tag, i), {31'h0, tx_pin}, {31'h0, exp_bits[i]});
    end
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] exp_a5;
    int c;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {31'h0, tx_pin}, 32'h1);
    checkOutput("rst_tx_full", {31'h0, tx_full}, 32'h0);
    checkOutput("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    checkOutput("rst_rx_empty", {31'h0, rx_empty}, 32'h1);
    checkOutput("rst_rx_rdata", {24'h0, rx_rdata}, 32'h0);
    checkOutput("rst_errs", {29'h0, parity_err, frame_err, overrun}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // TX waveform of 0xA5, no parity
    exp_a5 = frameBits(8'hA5, 1'b0, 1'b0);
    applyStimulus(8'hA5, 1'b0);
    checkOutput("a5_busy_rise", {31'h0, tx_busy}, 32'h1);
    c = 0;
    while (tx_pin && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput("a5_start_latency", {31'h0, tx_pin}, 32'h0);
    c = 0;
    while (!tx_pin && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput("a5_bit_period", c, 64);
    repeat (32) @(negedge clk);
    for (int i = 1; i < 10; i++) begin
      if (i != 1) repeat (64) @(negedge clk);
      checkOutput($sformatf("a5_bit%0d", i), {31'h0, tx_pin}, {31'h0, exp_a5[i]});
    end
    repeat (28) @(negedge clk);
    checkOutput("a5_busy_in_stop", {31'h0, tx_busy}, 32'h1);
    repeat (5) @(negedge clk);
    checkOutput("a5_busy_fall", {31'h0, tx_busy}, 32'h0);

    // Loopback, even parity then odd parity with two stop bits
    loop_en = 1'b1;
    parity_mode = 2'b01;
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) popAndCheck($sformatf("loop_even_%0d", i));
    checkOutput("loop_even_perr", {31'h0, parity_err}, 32'h0);
    parity_mode = 2'b10;
    stop2 = 1'b1;
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) popAndCheck($sformatf("loop_odd_%0d", i));
    checkOutput("loop_odd_perr", {31'h0, parity_err}, 32'h0);
    checkOutput("loop_ferr", {31'h0, frame_err}, 32'h0);
    repeat (200) @(negedge clk);
    loop_en = 1'b0;
    stop2 = 1'b0;
    parity_mode = 2'b01;

    // Wrong even parity on 0x55
    sendFrame(8'h55, PAR_EN, ~(^8'h55), 1'b0, 1'b1);
    popAndCheck("perr_word");
    checkOutput("perr_set", {31'h0, parity_err}, {31'h0, PAR_EN});
    pulseErrClr();
    checkOutput("perr_clr", {31'h0, parity_err}, 32'h0);

    // Start-bit glitch then a frame with a low stop bit
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("glitch_empty", {31'h0, rx_empty}, 32'h1);
    sendFrame(8'h96, PAR_EN, ^8'h96, 1'b1, 1'b1);
    popAndCheck("ferr_word");
    checkOutput("ferr_set", {31'h0, frame_err}, 32'h1);
    repeat (100) @(negedge clk);
    pulseErrClr();
    checkOutput("ferr_clr", {31'h0, frame_err}, 32'h0);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++)
      sendFrame(8'h11 * (i + 1), PAR_EN, ^(8'h11 * (i + 1)), 1'b0, i < 4);
    checkOutput("ovr_set", {31'h0, overrun}, 32'h1);
    checkOutput("ovr_head", {24'h0, rx_rdata}, exp_q[0]);
    for (int i = 0; i < 4; i++) popAndCheck($sformatf("ovr_pop_%0d", i));
    checkOutput("ovr_drained", {31'h0, rx_empty}, 32'h1);
    pulseErrClr();
    checkOutput("ovr_clr", {31'h0, overrun}, 32'h0);

    // Full FIFO read in the same cycle a new frame lands
    for (int i = 0; i < 4; i++) sendFrame(8'hA0 + 8'(i), PAR_EN, ^(8'hA0 + 8'(i)), 1'b0, 1'b1);
    fork
      sendFrame(8'h7E, PAR_EN, ^8'h7E, 1'b0, 1'b1);
      readOnPush("simul");
    join
    checkOutput("simul_no_ovr", {31'h0, overrun}, 32'h0);
    for (int i = 0; i < 4; i++) popAndCheck($sformatf("simul_pop_%0d", i));

    // Reset in the middle of a looped-back TX frame
    parity_mode = 2'b00;
    loop_en = 1'b1;
    applyStimulus(8'h5A, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    c = 0;
    while (tx_pin && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (150) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("rst_mid_tx_async", {31'h0, tx_pin}, 32'h1);
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'h0, tx_busy}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("rst_mid_rx_empty", {31'h0, rx_empty}, 32'h1);
    checkOutput("rst_mid_tx_idle", {31'h0, tx_pin}, 32'h1);
    applyStimulus(8'hC3, 1'b1);
    captureFrame("post_rst", frameBits(8'hC3, 1'b0, 1'b0), 10);
    popAndCheck("post_rst_rx");
    repeat (40) @(negedge clk);
    checkOutput("post_rst_busy", {31'h0, tx_busy}, 32'h0);
    checkOutput("sb_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_core_param.md
# uart_core_param

Parametrised full-duplex UART core that generalises the fixed-function loopback protocol block: generic data width and FIFO depth, runtime baud divisor, selectable parity, one or two stop bits, and a host-side push/pop interface in place of the hard-wired RX-to-TX loop. It sits between the system bus adapter and the external serial pins. It is self-contained: oversampling tick generator, TX/RX FIFOs, transmitter and receiver FSMs.

## Interface
- DATA_SIZE, 8, data bits per frame (5..9)
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2
- SAMPLE, 16, oversampling ticks per bit; even, ≥8
- DVSR_WIDTH, 16, width of baud_dvsr
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- baud_dvsr  input  DVSR_WIDTH  tick period minus one, in clk cycles
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
- stop2  input  1  1 = two stop bits on TX; RX always checks only the first
- tx_wdata  input  DATA_SIZE  host data to transmit
- tx_wr  input  1  push tx_wdata into TX FIFO
- tx_full  output  1  TX FIFO full
- tx_busy  output  1  frame in progress or TX FIFO non-empty
- rx_rdata  output  DATA_SIZE  head of RX FIFO (first-word fall-through)
- rx_rd  input  1  pop RX FIFO
- rx_empty  output  1  RX FIFO empty
- err_clr  input  1  clears all sticky error flags
- parity_err, frame_err, overrun  output  1 each  sticky error flags
- rx  input  1  serial input, idle high
- tx  output  1  serial output, idle high

## Operation
- Tick generator: counter reloads from baud_dvsr; s_tick pulses one clk every baud_dvsr+1 cycles. A new baud_dvsr value takes effect at the next reload. baud_dvsr=0 gives a tick every cycle.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on s_tick with TX FIFO non-empty, pop the head into a shift register and enter START.
  - Each bit lasts SAMPLE ticks. Data bits go out LSB first.
  - PARITY is skipped when parity_mode is 00 or 11. Even parity bit = XOR of the data bits; odd parity bit = its inverse.
  - STOP lasts SAMPLE ticks, or 2×SAMPLE ticks when stop2=1.
  - parity_mode and stop2 are latched at START; changes mid-frame do not affect the current frame.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - rx passes through a 2-flop synchroniser first.
  - IDLE→START on a synchronised low.
  - At tick SAMPLE/2 of START: if rx is high, the start was a glitch; return to IDLE and push nothing.
  - Every following bit is sampled SAMPLE ticks after the previous sample point.
  - Mode is latched at START.
  - At the stop sample:
    - stop bit low sets frame_err;
    - parity mismatch sets parity_err;
    - the word is pushed even when a flag is set.
  - After the stop sample the FSM returns to IDLE and is immediately ready for the next start bit.
- FIFOs: binary pointers with one extra wrap bit; full/empty are registered.
  - Write when full: dropped. A host TX write when full is ignored silently. An RX frame arriving when full sets overrun.
  - Read when empty: ignored; pointers unchanged.
  - Simultaneous read and write when full: both performed; count unchanged.
  - Simultaneous read and write when empty: the write lands; empty deasserts next cycle.
- Error flags: set-dominant over err_clr in the same cycle.

## Timing
- Reset values:
  - tx=1, tx_full=0, tx_busy=0;
  - rx_empty=1, rx_rdata=0;
  - all error flags 0;
  - both FIFOs empty; both FSMs in IDLE; tick counter 0.
- Reset asserted mid-frame aborts immediately. tx returns high asynchronously, and partial RX data is discarded.
- tx_wr in cycle N: tx_busy=1 in N+1, tx_empty internal in N+1.
- The start bit begins at the first s_tick at or after N+1, within baud_dvsr+2 clk.
- Bit period = SAMPLE×(baud_dvsr+1) clk.
- RX push occurs in the cycle after the stop-sample tick. rx_empty falls and rx_rdata becomes valid one clk later.
- rx_rd in cycle M: rx_rdata shows the next entry in M+1.
- tx_busy falls in the cycle after the last stop tick when the FIFO is empty. Back-to-back frames have zero idle time.

## Configuration
- UART_PARITY_EN defined: parity generation, parity checking and parity_err are implemented as described.
- UART_PARITY_EN undefined:
  - parity_mode is ignored and treated as 00;
  - the PARITY states are removed;
  - parity_err is tied to 0;
  - the port list is unchanged.

## Test plan
- Reset, DATA_SIZE=8, baud_dvsr=3, SAMPLE=16, parity 00, then push 0xA5 -> tx emits 0,1,0,1,0,0,1,0,1,1 with each bit 64 clk; tx_busy falls after the stop bit.
- TX pins looped to RX, parity 01, push 0x3C,0xFF,0x00 -> same three words pop in order; parity_err=0. Repeat with odd parity -> same result.
- Drive RX with 0x55 and a wrong even-parity bit -> word 0x55 pushed, parity_err=1. Then err_clr -> parity_err=0.
- Drive a 4-tick low glitch on rx -> nothing pushed, rx_empty stays 1. Drive a frame with stop bit low -> word pushed, frame_err=1.
- FIFO_DEPTH=4: receive 5 frames without reading -> 4 stored, overrun=1, rx_rdata=first word. Simultaneous rx_rd and frame arrival when full -> no overrun.
- Assert reset mid-DATA of a TX frame -> tx=1 immediately; after release, FIFOs are empty and the next push transmits a complete, correct frame.
